// File: rtl/pll_reset_ctrl.sv
// PLL lock supervisor and core reset sequencer, clocked by the free-running reference clock.
// Define PLL_RST_LOSS_CNT_EN to add the saturating loss-of-lock counter output loss_cnt.
`timescale 1ns/1ps
module pll_reset_ctrl #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1048576,
    parameter int unsigned LOCK_FILTER    = 1024
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic [1:0] state,
`ifdef PLL_RST_LOSS_CNT_EN
    output logic [7:0] loss_cnt,
`endif
    output logic [7:0] retry_cnt
);

    localparam int unsigned MaxAb  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                      : LOCK_TIMEOUT;
    localparam int unsigned MaxCyc = (MaxAb > LOCK_FILTER) ? MaxAb : LOCK_FILTER;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] PrstLast = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] FiltLast = CntW'(LOCK_FILTER - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {
        StPrst = 2'd0,
        StWait = 2'd1,
        StFilt = 2'd2,
        StRun  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             retry_q, retry_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   lock_s;
`ifdef PLL_RST_LOSS_CNT_EN
    logic [7:0]             loss_q, loss_d;
`endif

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
`ifdef PLL_RST_LOSS_CNT_EN
        loss_d  = loss_q;
`endif
        if (soft_rst) begin
            state_d = StPrst;
        end else begin
            unique case (state_q)
                StPrst: begin
                    if (cnt_q == PrstLast) state_d = StWait;
                end
                StWait: begin
                    // Lock beats a simultaneous timeout.
                    if (lock_s) begin
                        state_d = StFilt;
                    end else if (cnt_q == WaitLast) begin
                        state_d = StPrst;
                        if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                    end
                end
                StFilt: begin
                    if (!lock_s) begin
                        state_d = StWait;
                    end else if (cnt_q == FiltLast) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_d = StPrst;
`ifdef PLL_RST_LOSS_CNT_EN
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
                    end
                end
                default: state_d = StPrst;
            endcase
        end

        cnt_d        = (soft_rst || (state_d != state_q)) ? '0 : cnt_q + CntOne;
        pll_rst_d    = (state_d == StPrst);
        core_rst_n_d = (state_d == StRun);

        // The lock flag means nothing while the PLL is held in reset, so the synchronizer is
        // flushed there; lock must then propagate afresh through every stage in WAIT.
        sync_d = (state_q == StPrst) ? '0 : {sync_q[SYNC_STAGES-2:0], locked};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StPrst;
            cnt_q        <= '0;
            sync_q       <= '0;
            retry_q      <= '0;
            pll_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            retry_q      <= retry_d;
            pll_rst_q    <= pll_rst_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

`ifdef PLL_RST_LOSS_CNT_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`endif

    assign pll_rst      = pll_rst_q;
    assign core_reset_n = core_rst_n_q;
    assign state        = state_q;
    assign retry_cnt    = retry_q;

endmodule
